// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, sign fix-up on exit.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        rem_q, rem_d;
  logic [WIDTH-1:0]        quo_q, quo_d;
  logic [WIDTH-1:0]        dvs_q, dvs_d;
  logic signed [WIDTH-1:0] dvd_q, dvd_d;
  logic                    sgnq_q, sgnq_d;
  logic                    sgnr_q, sgnr_d;
  logic                    zero_q, zero_d;
  logic signed [WIDTH-1:0] quot_q, quot_d;
  logic signed [WIDTH-1:0] rmd_q, rmd_d;
  logic                    done_q, done_d;
  logic                    dz_q, dz_d;

  logic [WIDTH:0]          rem_sh;
  logic [WIDTH:0]          trial;

  // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1) without loss.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return u[WIDTH-1] ? (~u + ONE) : u;
  endfunction

  function automatic logic signed [WIDTH-1:0] apply_sign(input logic neg,
                                                         input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] r;
    r = neg ? (~m + ONE) : m;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // Partial remainder is shifted into a WIDTH+1 bit window so the trial sign is exact.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    dvd_d  = dvd_q;
    sgnq_d = sgnq_q;
    sgnr_d = sgnr_q;
    zero_d = zero_q;
    quot_d = quot_q;
    rmd_d  = rmd_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          quo_d  = mag(dividend);
          dvs_d  = mag(divisor);
          dvd_d  = dividend;
          sgnq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sgnr_d = dividend[WIDTH-1];
          zero_d = (divisor == '0);
          rem_d  = '0;
          cnt_d  = '0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      FIX: begin
        done_d = 1'b1;
        if (zero_q) begin
          quot_d = '1;
          rmd_d  = dvd_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = apply_sign(sgnq_q, quo_q);
          rmd_d  = apply_sign(sgnr_q, rem_q);
          dz_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      sgnq_q <= 1'b0;
      sgnr_q <= 1'b0;
      zero_q <= 1'b0;
      quot_q <= '0;
      rmd_q  <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      dvd_q  <= dvd_d;
      sgnq_q <= sgnq_d;
      sgnr_q <= sgnr_d;
      zero_q <= zero_d;
      quot_q <= quot_d;
      rmd_q  <= rmd_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;

endmodule
